// File: rtl/core_dbg_apb_arb.sv
// Two-port round-robin APB master sharing the core debug APB slave between the
// JTAG debug transport (port 0) and the halt/resume sequencer (port 1).
module core_dbg_apb_arb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  r0_req,
    input  logic                  r0_wr_rd,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic [3:0]            r0_wstrobe,
    output logic                  r0_done,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic                  r0_err,

    input  logic                  r1_req,
    input  logic                  r1_wr_rd,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    input  logic [3:0]            r1_wstrobe,
    output logic                  r1_done,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  r1_err,

    output logic [ADDR_WIDTH-1:0] apb_addr,
    output logic                  apb_sel,
    output logic                  apb_enable,
    output logic                  apb_wr_rd,
    output logic [DATA_WIDTH-1:0] apb_wdata,
    output logic [3:0]            apb_wstrobe,
    input  logic                  apb_ready,
    input  logic [DATA_WIDTH-1:0] apb_rdata,

    output logic [1:0]            dbg_state
);

    // Requester handshake: rN_req is held with stable payload until the
    // one-cycle rN_done pulse; the requester drops it on the edge ending that cycle.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t                state, state_d;
    logic                  last_gnt, last_gnt_d;
    logic [CNT_W-1:0]      cnt, cnt_d;

    logic                  sel_d, en_d, wr_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [3:0]            strb_d;
    logic                  done0_d, done1_d, err0_d, err1_d;
    logic [DATA_WIDTH-1:0] rdata0_d, rdata1_d;

    logic                  pick1;
    logic                  fin, fin_err;
    logic [DATA_WIDTH-1:0] fin_data;

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            cnt         <= '0;
            apb_sel     <= 1'b0;
            apb_enable  <= 1'b0;
            apb_wr_rd   <= 1'b0;
            apb_addr    <= '0;
            apb_wdata   <= '0;
            apb_wstrobe <= '0;
            r0_done     <= 1'b0;
            r0_rdata    <= '0;
            r0_err      <= 1'b0;
            r1_done     <= 1'b0;
            r1_rdata    <= '0;
            r1_err      <= 1'b0;
        end else begin
            state       <= state_d;
            last_gnt    <= last_gnt_d;
            cnt         <= cnt_d;
            apb_sel     <= sel_d;
            apb_enable  <= en_d;
            apb_wr_rd   <= wr_d;
            apb_addr    <= addr_d;
            apb_wdata   <= wdata_d;
            apb_wstrobe <= strb_d;
            r0_done     <= done0_d;
            r0_rdata    <= rdata0_d;
            r0_err      <= err0_d;
            r1_done     <= done1_d;
            r1_rdata    <= rdata1_d;
            r1_err      <= err1_d;
        end
    end

    always_comb begin
        state_d    = state;
        last_gnt_d = last_gnt;
        cnt_d      = cnt;
        sel_d      = apb_sel;
        en_d       = apb_enable;
        wr_d       = apb_wr_rd;
        addr_d     = apb_addr;
        wdata_d    = apb_wdata;
        strb_d     = apb_wstrobe;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        err0_d     = 1'b0;
        err1_d     = 1'b0;
        rdata0_d   = '0;
        rdata1_d   = '0;
        fin        = 1'b0;
        fin_err    = 1'b0;
        fin_data   = '0;

        // Port 1 wins when alone, or on a tie when port 0 was served last.
        pick1 = r1_req && (!r0_req || !last_gnt);

        case (state)
            IDLE: begin
                if (r0_req || r1_req) begin
                    last_gnt_d = pick1;
                    wr_d       = pick1 ? r1_wr_rd   : r0_wr_rd;
                    addr_d     = pick1 ? r1_addr    : r0_addr;
                    wdata_d    = pick1 ? r1_wdata   : r0_wdata;
                    strb_d     = pick1 ? r1_wstrobe : r0_wstrobe;
                    sel_d      = 1'b1;
                    en_d       = 1'b0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                sel_d   = 1'b1;
                en_d    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (apb_ready) begin
                    fin      = 1'b1;
                    fin_data = apb_wr_rd ? '0 : apb_rdata;
                end else if (TIMEOUT != 0) begin
                    // Abort on reaching the limit, so the counter never passes CNT_MAX.
                    if (cnt == CNT_MAX) begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fin) begin
            state_d = DONE;
            sel_d   = 1'b0;
            en_d    = 1'b0;
            if (last_gnt) begin
                done1_d  = 1'b1;
                rdata1_d = fin_data;
                err1_d   = fin_err;
            end else begin
                done0_d  = 1'b1;
                rdata0_d = fin_data;
                err0_d   = fin_err;
            end
        end
    end

endmodule
